// File: rtl/mem_handshake_ctrl_pkg.sv
// Shared definitions for the memory handshake controller: access sizes,
// FSM encoding and the alignment check used by the optional fault path.
package mem_ctrl_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    WAIT    = ST_WAIT,
    STROBE  = ST_STROBE,
    CAPTURE = ST_CAPTURE,
    DONE    = ST_DONE
  } state_t;

  // Reserved size 2'b11 behaves as a word access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = off[0];
      default:   misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_handshake_ctrl_if.sv
// Datapath request/response and RAM port bundle for mem_handshake_ctrl.
// The fault signal exists only when MEM_ALIGN_FAULT_EN is defined.
interface mem_handshake_ctrl_if;
  logic        mov;
  logic        rw;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mfc;
  logic [31:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef MEM_ALIGN_FAULT_EN
  logic        fault;
`endif

  modport slave (
`ifdef MEM_ALIGN_FAULT_EN
    output fault,
`endif
    input  mov, rw, size, addr, wdata, mem_rdata,
    output mfc, rdata, mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
`ifdef MEM_ALIGN_FAULT_EN
    input  fault,
`endif
    output mov, rw, size, addr, wdata, mem_rdata,
    input  mfc, rdata, mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_handshake_ctrl_lane_align.sv
// Little-endian lane steering: byte enables and store replication on the way
// out, lane extraction with zero-extension on the way back.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] ram_word,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] rext
);

  logic [7:0] rbyte;

  always_comb begin
    be    = 4'b1111;
    wrep  = wdata;
    rext  = ram_word;
    rbyte = ram_word[{off, 3'b000} +: 8];
    case (size)
      SIZE_BYTE: begin
        be   = 4'b0001 << off;
        wrep = {4{wdata[7:0]}};
        rext = {24'h0, rbyte};
      end
      SIZE_HALF: begin
        // off[0] is ignored: halfwords always land on a lane pair.
        be   = off[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
        rext = off[1] ? {16'h0, ram_word[31:16]} : {16'h0, ram_word[15:0]};
      end
      default: begin
        be   = 4'b1111;
        wrep = wdata;
        rext = ram_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_handshake_ctrl.sv
// Fixed-latency MOV/MFC memory controller for a synchronous 32-bit word RAM.
// Optional MEM_ALIGN_FAULT_EN flags misaligned half/word accesses instead of aligning them.
module mem_handshake_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  mem_handshake_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              rw_q;
  logic [1:0]        size_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              abort_q;
  logic              mfc_q;
  logic [31:0]       rdata_q;
  logic              flt_in;
  logic              flt_q;
  logic [3:0]        be;
  logic [31:0]       wrep;
  logic [31:0]       rext;

  mem_lane_align u_align (
    .size     (size_q),
    .off      (addr_q[1:0]),
    .wdata    (wdata_q),
    .ram_word (bus.mem_rdata),
    .be       (be),
    .wrep     (wrep),
    .rext     (rext)
  );

`ifdef MEM_ALIGN_FAULT_EN
  logic fault_q;
  assign flt_in    = misaligned(bus.size, bus.addr[1:0]);
  assign bus.fault = fault_q;
`else
  assign flt_in = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.mov) begin
          if (flt_in)                state_d = CAPTURE;
          else if (WAIT_CYCLES == 0) state_d = STROBE;
          else                       state_d = WAIT;
        end
      end
      WAIT: begin
        if (!bus.mov)                   state_d = IDLE;
        else if (cnt_q == CNT_W'(1))    state_d = STROBE;
      end
      STROBE:  state_d = CAPTURE;
      // An access that lost mov after issue still completes, but never signals mfc.
      CAPTURE: state_d = (bus.mov && !abort_q) ? DONE : IDLE;
      DONE:    if (!bus.mov) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      abort_q <= 1'b0;
      flt_q   <= 1'b0;
      mfc_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.mov) begin
            rw_q    <= bus.rw;
            size_q  <= bus.size;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            cnt_q   <= CNT_W'(WAIT_CYCLES);
            abort_q <= 1'b0;
            flt_q   <= flt_in;
          end
        end
        WAIT:    cnt_q <= cnt_q - 1'b1;
        STROBE:  if (!bus.mov) abort_q <= 1'b1;
        CAPTURE: if (rw_q && !flt_q) rdata_q <= rext;
        default: ;
      endcase
      mfc_q <= (state_q == DONE) && bus.mov;
    end
  end

`ifdef MEM_ALIGN_FAULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= (state_q == DONE) && bus.mov && flt_q;
  end
`endif

  // RAM strobe and qualifiers decode straight from the state register.
  assign bus.mem_en    = (state_q == STROBE);
  assign bus.mem_we    = (state_q == STROBE) && !rw_q;
  assign bus.mem_be    = (state_q == STROBE) ? be : 4'b0000;
  assign bus.mem_addr  = addr_q[31:2];
  assign bus.mem_wdata = wrep;
  assign bus.mfc       = mfc_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// Scoreboard bench for mem_handshake_ctrl: directed requests push expected
// strobe and completion records; a negedge monitor pops and compares them.
module tb_mem_handshake_ctrl;
  import mem_ctrl_pkg::*;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } sexp_t;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          rq;
    logic        flt;
  } dexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;
  logic mfc_d = 1'b0;
  logic en_d = 1'b0;
  logic [31:0] ram [0:255];
  sexp_t sq[$];
  dexp_t dq[$];

  mem_handshake_ctrl_if bus();

  mem_handshake_ctrl #(.WAIT_CYCLES(2), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous word RAM: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int i = 0; i < 4; i++)
          if (bus.mem_be[i]) ram[bus.mem_addr[7:0]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      end else begin
        bus.mem_rdata <= ram[bus.mem_addr[7:0]];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every strobe and every mfc rise against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_en) begin
        en_cnt++;
        chk("strobe_single", {31'h0, en_d}, 32'h0);
        if (sq.size() == 0) chk("unexpected_strobe", 32'h1, 32'h0);
        else begin
          sexp_t s;
          s = sq.pop_front();
          chk("mem_addr", {2'b00, bus.mem_addr}, {2'b00, s.addr});
          chk("mem_be", {28'h0, bus.mem_be}, {28'h0, s.be});
          chk("mem_we", {31'h0, bus.mem_we}, {31'h0, s.we});
          chk("mem_wdata", bus.mem_wdata, s.wdata);
        end
      end
      if (bus.mfc && !mfc_d) begin
        if (dq.size() == 0) chk("unexpected_mfc", 32'h1, 32'h0);
        else begin
          dexp_t d;
          d = dq.pop_front();
          chk("rdata", bus.rdata, d.rdata);
          chk("mfc_latency", cyc - d.rq, d.lat);
`ifdef MEM_ALIGN_FAULT_EN
          chk("fault", {31'h0, bus.fault}, {31'h0, d.flt});
`endif
        end
      end
    end
    mfc_d = bus.mfc;
    en_d  = bus.mem_en;
  end

  task automatic req(input logic rw_i, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic strobe, input logic [3:0] be_e,
                     input logic [31:0] mw_e, input logic [31:0] rd_e, input int lat,
                     input logic flt);
    sexp_t s;
    dexp_t d;
    int n;
    if (strobe) begin
      s = '{a[31:2], be_e, ~rw_i, mw_e};
      sq.push_back(s);
    end
    d = '{rd_e, lat, cyc + 1, flt};
    dq.push_back(d);
    bus.rw = rw_i; bus.size = sz; bus.addr = a; bus.wdata = wd; bus.mov = 1'b1;
    @(negedge clk);
    // Scramble request fields mid-access; they must have been latched.
    bus.rw = ~rw_i; bus.size = ~sz; bus.addr = 32'hFFFF_FFFF; bus.wdata = 32'h5A5A_5A5A;
    n = 0;
    while (!bus.mfc && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.mfc) chk("mfc_timeout", 32'h0, 32'h1);
    bus.mov = 1'b0;
    @(negedge clk);
    chk("mfc_clear", {31'h0, bus.mfc}, 32'h0);
`ifdef MEM_ALIGN_FAULT_EN
    chk("fault_clear", {31'h0, bus.fault}, 32'h0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[0]     = 32'h1234_5678;
    ram[8'h40] = 32'hDEAD_BEEF;
    bus.mov = 1'b0; bus.rw = 1'b0; bus.size = 2'b00; bus.addr = '0; bus.wdata = '0;
    bus.mem_rdata = '0;
    #12;
    chk("rst_mfc", {31'h0, bus.mfc}, 32'h0);
    chk("rst_mem_en", {31'h0, bus.mem_en}, 32'h0);
    chk("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_mem_addr", {2'b00, bus.mem_addr}, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    //   rw    size       addr          wdata         stb  be       mem_wdata     rdata         lat flt
    req(1'b1, SIZE_WORD, 32'h0000_0100, 32'h0,        1'b1, 4'b1111, 32'h0,        32'hDEAD_BEEF, 5, 1'b0);
    req(1'b0, SIZE_BYTE, 32'h0000_0103, 32'h0000_00A5, 1'b1, 4'b1000, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 5, 1'b0);
    req(1'b1, SIZE_BYTE, 32'h0000_0103, 32'h0,        1'b1, 4'b1000, 32'h0,        32'h0000_00A5, 5, 1'b0);
    req(1'b1, SIZE_HALF, 32'h0000_0002, 32'h0,        1'b1, 4'b1100, 32'h0,        32'h0000_1234, 5, 1'b0);
    req(1'b1, SIZE_HALF, 32'h0000_0000, 32'h0,        1'b1, 4'b0011, 32'h0,        32'h0000_5678, 5, 1'b0);
    req(1'b0, SIZE_HALF, 32'h0000_0006, 32'h0000_BEEF, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0000_5678, 5, 1'b0);
    req(1'b1, SIZE_WORD, 32'h0000_0004, 32'h0,        1'b1, 4'b1111, 32'h0,        32'hBEEF_0000, 5, 1'b0);
`ifndef MEM_ALIGN_FAULT_EN
    req(1'b1, SIZE_WORD, 32'h0000_0103, 32'h0,        1'b1, 4'b1111, 32'h0,        32'hA5AD_BEEF, 5, 1'b0);
    req(1'b1, SIZE_HALF, 32'h0000_0103, 32'h0,        1'b1, 4'b1100, 32'h0,        32'h0000_A5AD, 5, 1'b0);
`endif

    // Abort while waiting: no strobe, no mfc.
    en0 = en_cnt;
    bus.rw = 1'b1; bus.size = SIZE_WORD; bus.addr = 32'h0; bus.mov = 1'b1;
    @(negedge clk); bus.mov = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_wait_no_strobe", en_cnt, en0);
    chk("abort_wait_no_mfc", {31'h0, bus.mfc}, 32'h0);
    req(1'b1, SIZE_WORD, 32'h0000_0000, 32'h0, 1'b1, 4'b1111, 32'h0, 32'h1234_5678, 5, 1'b0);

    // Abort during strobe: access completes into rdata, mfc never rises.
    sq.push_back('{30'h1, 4'b1111, 1'b0, 32'h0});
    bus.rw = 1'b1; bus.size = SIZE_WORD; bus.addr = 32'h4; bus.wdata = 32'h0; bus.mov = 1'b1;
    repeat (3) @(negedge clk);
    bus.mov = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_strobe_rdata", bus.rdata, 32'hBEEF_0000);
    chk("abort_strobe_no_mfc", {31'h0, bus.mfc}, 32'h0);

    // Reset during CAPTURE clears outputs without a clock edge.
    sq.push_back('{30'h0, 4'b1111, 1'b0, 32'h0});
    bus.addr = 32'h0; bus.mov = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_mfc", {31'h0, bus.mfc}, 32'h0);
    chk("midrst_mem_en", {31'h0, bus.mem_en}, 32'h0);
    chk("midrst_rdata", bus.rdata, 32'h0);
    bus.mov = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    req(1'b1, SIZE_WORD, 32'h0000_0004, 32'h0, 1'b1, 4'b1111, 32'h0, 32'hBEEF_0000, 5, 1'b0);

`ifdef MEM_ALIGN_FAULT_EN
    en0 = en_cnt;
    req(1'b1, SIZE_WORD, 32'h0000_0102, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hBEEF_0000, 2, 1'b1);
    chk("fault_no_strobe", en_cnt, en0);
    req(1'b1, SIZE_HALF, 32'h0000_0003, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hBEEF_0000, 2, 1'b1);
`endif

    repeat (2) @(negedge clk);
    chk("strobe_queue_empty", sq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
